// File: rtl/jk_cmd_driver_pkg.sv
// rtl/jk_cmd_driver_pkg.sv - op encodings, FSM state type and JK helpers for jk_cmd_driver
package jk_cmd_driver_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // FIFO entry is {op, count}
    localparam int CMD_W = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

    // Returns {j, k} for an op
    function automatic logic [1:0] op_drive(input logic [1:0] op);
        case (op)
            OP_HOLD:   return 2'b00;
            OP_RESET:  return 2'b01;
            OP_SET:    return 2'b10;
            OP_TOGGLE: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_driver_cmd_fifo.sv
// rtl/jk_cmd_driver_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// rtl/jk_cmd_driver.sv - queued JK flip-flop command driver with expected-Q checker
module jk_cmd_driver
    import jk_cmd_driver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_count,
    output logic       j,
    output logic       k,
    input  logic       q_in,
    output logic       exp_q,
    output logic       mismatch,
    output logic       busy,
    output logic       done
);

    logic [CMD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    state_t           state;
    logic [3:0]       cnt;

    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    // Pop whenever the FSM is free: idle, or on the final cycle of the current op
    assign pop       = ~empty & ((state == IDLE) | (cnt == 4'd0));
    assign busy      = (state == ISSUE) | ~empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cmd_op, cmd_count}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= ISSUE;
                        cnt      <= head[3:0];
                        {j, k}   <= op_drive(head[5:4]);
                    end else begin
                        j <= 1'b0;
                        k <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (pop) begin
                        cnt    <= head[3:0];
                        {j, k} <= op_drive(head[5:4]);
                    end else begin
                        state <= IDLE;
                        j     <= 1'b0;
                        k     <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            exp_q <= jk_next(j, k, exp_q);
            if (q_in != exp_q) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb/tb_jk_cmd_driver.sv - scoreboard bench for jk_cmd_driver with a modelled downstream JK flip-flop
module tb_jk_cmd_driver;
    import jk_cmd_driver_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_count = 4'd0;
    logic       cmd_ready, j, k, q_in, exp_q, mismatch, busy, done;
    logic       ff_q;
    logic       force_zero = 1'b0;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] sb [$];
    logic [1:0] mon_exp;

    int         act, dones, bad_done, first, last, done_at;
    logic       qlog [0:31];

    always #5 clk = ~clk;

    jk_cmd_driver #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .exp_q     (exp_q),
        .mismatch  (mismatch),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_in = force_zero ? 1'b0 : ff_q;

    function automatic logic [1:0] drv(input logic [1:0] op);
        return {(op == OP_SET) || (op == OP_TOGGLE), (op == OP_RESET) || (op == OP_TOGGLE)};
    endfunction

    always @(negedge clk) begin
        if (!rst && (j || k)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: jk=%b with no command pending", {j, k});
            end else begin
                mon_exp = sb.pop_front();
                if ({j, k} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_drive: jk=%b expected %b", {j, k}, mon_exp);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; force_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] c, output int stalls);
        bit rdy;
        int guard;
        guard = 0; stalls = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = c;
        do begin
            rdy = cmd_ready;
            if (!rdy) stalls++;
            @(posedge clk); #1;
            guard++;
        end while (!rdy && guard < 200);
        cmd_valid = 1'b0;
        n_checks++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
        end else begin
            for (int i = 0; i <= int'(c); i++) sb.push_back(drv(op));
        end
    endtask

    task automatic observe(input int ncyc);
        logic prev_busy;
        act = 0; dones = 0; bad_done = 0; first = -1; last = -1; done_at = -1;
        prev_busy = busy;
        for (int c = 0; c < ncyc; c++) begin
            if (j || k) begin
                if (first < 0) first = c;
                last = c;
                if (act < 32) qlog[act] = exp_q;
                act++;
            end
            if (done) begin
                dones++;
                if (done_at < 0) done_at = c;
                if (!prev_busy) bad_done++;
            end
            prev_busy = busy;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (j !== 1'b0) begin n_fail++; $display("FAIL reset_j: got %b required 0", j); end
        n_checks++; if (k !== 1'b0) begin n_fail++; $display("FAIL reset_k: got %b required 0", k); end
        n_checks++; if (exp_q !== 1'b0) begin n_fail++; $display("FAIL reset_exp_q: got %b required 0", exp_q); end
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch: got %b required 0", mismatch); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    endtask

    task automatic test_single_set();
        int st;
        send(OP_SET, 4'd2, st);
        n_checks++; if (j !== 1'b0) begin n_fail++; $display("FAIL set_latency_early: j=%b required 0", j); end
        observe(12);
        n_checks++; if (first !== 1) begin n_fail++; $display("FAIL set_latency: first active %0d required 1", first); end
        n_checks++; if (act !== 3) begin n_fail++; $display("FAIL set_cycles: got %0d required 3", act); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL set_done_count: got %0d required 1", dones); end
        n_checks++; if (done_at !== last + 1) begin n_fail++; $display("FAIL set_done_pos: got %0d required %0d", done_at, last + 1); end
        n_checks++; if (bad_done !== 0) begin n_fail++; $display("FAIL set_done_busy: got %0d required 0", bad_done); end
        n_checks++; if (exp_q !== 1'b1 || q_in !== 1'b1) begin n_fail++; $display("FAIL set_q: exp_q=%b q_in=%b required 1,1", exp_q, q_in); end
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL set_mismatch: got %b required 0", mismatch); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL set_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int st;
        logic exp_log [0:4];
        exp_log = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        send(OP_TOGGLE, 4'd3, st);
        send(OP_RESET, 4'd0, st);
        observe(15);
        n_checks++; if (act !== 5) begin n_fail++; $display("FAIL b2b_cycles: got %0d required 5", act); end
        n_checks++; if (last - first + 1 !== 5) begin n_fail++; $display("FAIL b2b_gap: span %0d required 5", last - first + 1); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (qlog[i] !== exp_log[i]) begin n_fail++; $display("FAIL b2b_exp_q[%0d]: got %b required %b", i, qlog[i], exp_log[i]); end
        end
        n_checks++; if (dones !== 1 || done_at !== last + 1) begin n_fail++; $display("FAIL b2b_done: count %0d at %0d required 1 at %0d", dones, done_at, last + 1); end
        n_checks++; if (exp_q !== 1'b0) begin n_fail++; $display("FAIL b2b_final_q: got %b required 0", exp_q); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL b2b_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_fill();
        int st, stall_total;
        logic [1:0] ops [0:5];
        ops = '{OP_SET, OP_RESET, OP_TOGGLE, OP_SET, OP_RESET, OP_TOGGLE};
        do_reset();
        stall_total = 0;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], 4'd15, st);
            stall_total += st;
        end
        n_checks++; if (stall_total < 1) begin n_fail++; $display("FAIL fill_backpressure: stalls %0d required >=1", stall_total); end
        observe(120);
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL fill_done: got %0d required 1", dones); end
        n_checks++; if (bad_done !== 0) begin n_fail++; $display("FAIL fill_done_busy: got %0d required 0", bad_done); end
        n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL fill_dropped: %0d entries never issued, required 0", sb.size()); end
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL fill_mismatch: got %b required 0", mismatch); end
    endtask

    task automatic test_fault();
        int st, guard;
        do_reset();
        force_zero = 1'b1;
        send(OP_SET, 4'd5, st);
        guard = 0;
        while (exp_q !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (exp_q !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_exp_q_timeout: exp_q=%b required 1", exp_q);
        end else begin
            n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL fault_early: mismatch=%b required 0", mismatch); end
            @(posedge clk); #1;
            n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL fault_detect: mismatch=%b required 1", mismatch); end
        end
        force_zero = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: mismatch=%b required 1", mismatch); end
        do_reset();
        n_checks++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL fault_clear: mismatch=%b required 0", mismatch); end
    endtask

    task automatic test_abort();
        int st;
        do_reset();
        send(OP_TOGGLE, 4'd7, st);
        send(OP_SET, 4'd3, st);
        send(OP_RESET, 4'd3, st);
        n_checks++; if ({j, k} !== 2'b11) begin n_fail++; $display("FAIL abort_pre: jk=%b required 11", {j, k}); end
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_count = 4'd0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        n_checks++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL abort_jk: jk=%b required 00", {j, k}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b required 1", cmd_ready); end
        observe(30);
        n_checks++; if (act !== 0) begin n_fail++; $display("FAIL abort_issued: %0d active cycles required 0", act); end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_done: %0d pulses required 0", dones); end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_back_to_back();
        test_fill();
        test_fault();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jk_cmd_driver.md
JK_CMD_DRIVER -- requirements
Module: jk_cmd_driver

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  upstream command present.
REQ-005 Port: cmd_ready  output  1  FIFO can accept; equals not-full, registered-state only.
REQ-006 Port: cmd_op  input  2  00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 Port: cmd_count  input  4  command applied for cmd_count+1 consecutive cycles.
REQ-008 Port: j  output  1  registered J drive to downstream JK flip-flop.
REQ-009 Port: k  output  1  registered K drive to downstream JK flip-flop.
REQ-010 Port: q_in  input  1  Q fed back from downstream flip-flop (same clk/rst).
REQ-011 Port: exp_q  output  1  modelled expected Q.
REQ-012 Port: mismatch  output  1  sticky flag, q_in differed from exp_q.
REQ-013 Port: busy  output  1  FSM in ISSUE or FIFO non-empty.
REQ-014 Port: done  output  1  one-cycle pulse when last queued command finishes.

Function
REQ-015 Handshake: command pushed on rising edge when cmd_valid and cmd_ready both high; cmd_valid while cmd_ready low -> no push, nothing lost.
REQ-016 FIFO: first-in first-out, depth FIFO_DEPTH; simultaneous push and pop when non-full -> occupancy unchanged; full -> cmd_ready low even if pop occurs same cycle.
REQ-017 Op encoding to drive: hold j=0,k=0; reset j=0,k=1; set j=1,k=0; toggle j=1,k=1.
REQ-018 FSM states IDLE, ISSUE only.
REQ-019 IDLE: j=k=0; FIFO non-empty -> pop head, load op and repeat counter = cmd_count, go ISSUE; j/k reflect op from next cycle.
REQ-020 Latency: command pushed at edge N into empty FIFO while IDLE -> j/k valid during cycle after edge N+1.
REQ-021 ISSUE: j/k held at op's encoding; counter decrements each cycle; counter 0 and FIFO non-empty -> pop next with no bubble cycle; counter 0 and FIFO empty -> IDLE, done high one cycle, j=k=0.
REQ-022 exp_q updated each edge from current j/k and exp_q with JK rule: next = (j & ~exp_q) | (~k & exp_q).
REQ-023 Comparison: every cycle after reset release, q_in != exp_q -> mismatch set next edge; mismatch stays high until rst.
REQ-024 busy = (state == ISSUE) or FIFO non-empty; done never asserted with busy low in preceding cycle.
REQ-025 cmd_count=0 -> op applied exactly one cycle.

Reset
REQ-026 rst high at edge: FIFO flushed (empty), state IDLE, counter 0, j=0, k=0, exp_q=0, mismatch=0, done=0, busy=0, cmd_ready=1 from next cycle.
REQ-027 rst mid-ISSUE aborts current and queued commands, no done pulse; a push coincident with rst is discarded.
REQ-028 Downstream flip-flop reset to Q=0 by same rst, so exp_q=0 matches.

Structure
REQ-029 Shared package holds op encoding constants (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE), FSM state typedef, and the JK next-state function used for exp_q.
REQ-030 One sub-module: cmd_fifo (synchronous FIFO, depth FIFO_DEPTH, width 6, full/empty flags); FSM, counter and checker in jk_cmd_driver.

Verification
REQ-031 Reset: rst 2 cycles -> j=k=0, exp_q=0, mismatch=0, cmd_ready=1, busy=0.
REQ-032 Single set, cmd_count=2, real JK FF attached -> j=1,k=0 for exactly 3 cycles, q_in=exp_q=1, done one pulse, mismatch=0.
REQ-033 Back-to-back toggle(count 3), reset(count 0) -> toggle 4 cycles then reset 1 cycle with no gap; exp_q 0,1,0,1,0 then 0; done once after the reset cycle.
REQ-034 Fill: cmd_valid held high, 6 commands of count 15 with FIFO_DEPTH=4 -> cmd_ready drops when full, all 6 issued in order, none dropped.
REQ-035 Fault: q_in forced to 0 during set command -> mismatch high one cycle after first difference, stays high until rst.
REQ-036 rst asserted mid-toggle with 2 commands queued -> next cycle j=k=0, busy=0, no done, later commands not issued.
